// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer
// Sequential instruction prefetcher between a variable-latency instruction
// memory and the decode stage. Requests are credit-limited so that every
// response that is kept always finds a free queue slot. A taken redirect
// flushes the queue. The redirect also marks every in-flight request as one
// whose response must be dropped.
//
// Build option: define IPB_BYPASS_EN to let a response reach the decode-facing
// outputs in the same cycle it returns, provided the queue is empty and
// nothing is pending drop. Without it, every output is driven from queue state.
//
// DEPTH must be a power of two and at least 2.

module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    localparam int unsigned PW      = $clog2(DEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   fetch_pc;

    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [PW-1:0] q_rd_ptr;
    logic [PW-1:0] q_wr_ptr;
    logic [CW-1:0] count;

    // PCs of requests still in flight, in issue order. Dropped responses pop
    // their tag as well, so after a redirect this FIFO realigns by itself.
    logic [31:0]   tag_pc  [DEPTH];
    logic [PW-1:0] tag_rd_ptr;
    logic [PW-1:0] tag_wr_ptr;

    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_nxt;
    logic [CW-1:0] drop;

    logic          req_fire;
    logic          rsp_keep;
    logic          head_valid;
    logic          bypass;
    logic          push;
    logic          pop;
    logic [31:0]   rsp_pc;
    logic [31:0]   head_pc;
    logic          unused_pc_bits;

    assign unused_pc_bits   = ^redirect_pc_i[1:0];

    assign imem_req_valid_o = rst && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
    assign imem_req_addr_o  = fetch_pc;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    assign rsp_pc           = tag_pc[tag_rd_ptr];
    assign rsp_keep         = imem_rsp_valid_i && (drop == '0) && !redirect_i;
    assign head_valid       = (count != '0);
    assign head_pc          = q_pc[q_rd_ptr];

`ifdef IPB_BYPASS_EN
    assign bypass = !head_valid && (drop == '0) && !redirect_i && imem_rsp_valid_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed response consumed by decode in the same cycle never enters the queue.
    assign push          = rsp_keep && !(bypass && instr_ready_i);
    assign pop           = head_valid && instr_ready_i && !redirect_i;
    assign instr_valid_o = head_valid || bypass;

    // Net change of in-flight requests: +1 per accepted request, -1 per response.
    always_comb begin
        outstanding_nxt = outstanding;
        if (req_fire && !imem_rsp_valid_i) begin
            outstanding_nxt = outstanding + CW'(1);
        end else if (!req_fire && imem_rsp_valid_i) begin
            outstanding_nxt = outstanding - CW'(1);
        end
    end

    // Control state: fetch address, queue pointers/count, credit and drop counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            q_rd_ptr    <= '0;
            q_wr_ptr    <= '0;
            count       <= '0;
            tag_rd_ptr  <= '0;
            tag_wr_ptr  <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (req_fire) begin
                tag_wr_ptr <= tag_wr_ptr + PW'(1);
            end
            if (imem_rsp_valid_i) begin
                tag_rd_ptr <= tag_rd_ptr + PW'(1);
            end

            if (redirect_i) begin
                // Every request still in flight after this edge returns stale data.
                fetch_pc <= {redirect_pc_i[31:2], 2'b00};
                q_rd_ptr <= '0;
                q_wr_ptr <= '0;
                count    <= '0;
                drop     <= outstanding_nxt;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    q_wr_ptr <= q_wr_ptr + PW'(1);
                end
                if (pop) begin
                    q_rd_ptr <= q_rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
                if (imem_rsp_valid_i && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    // Storage arrays: request tags and queued {instr, pc} entries (no reset needed).
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_pc[tag_wr_ptr] <= fetch_pc;
        end
        if (push) begin
            q_instr[q_wr_ptr] <= imem_rsp_data_i;
            q_pc[q_wr_ptr]    <= rsp_pc;
        end
    end

    // Decode-facing outputs: queue head, optional same-cycle bypass, else empty values.
    always_comb begin
        instr_o    = NOP;
        pc_o       = '0;
        pc_plus4_o = '0;
        if (head_valid) begin
            instr_o    = q_instr[q_rd_ptr];
            pc_o       = head_pc;
            pc_plus4_o = head_pc + 32'd4;
        end else if (bypass) begin
            instr_o    = imem_rsp_data_i;
            pc_o       = rsp_pc;
            pc_plus4_o = rsp_pc + 32'd4;
        end
    end

    // A response with nothing in flight means the memory has lost sync with us.
    rsp_without_req: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid_i |-> (outstanding != '0));

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer
// Randomized bench for instr_prefetch_buffer (default build, no bypass).
// Reference model: a queue of delivered {instr, pc} entries and a queue of
// in-flight requests carrying a stale flag. The memory model returns
// responses in order, after a per-segment latency.

module tb_instr_prefetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .instr_valid_o    (instr_valid_o),
        .instr_ready_i    (instr_ready_i),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .pc_plus4_o       (pc_plus4_o)
    );

    typedef struct packed { logic [31:0] instr; logic [31:0] pc; } entry_t;
    typedef struct packed { logic [31:0] pc; logic stale; } flight_t;
    typedef struct packed { logic [31:0] addr; int due; } mreq_t;

    entry_t      fq[$];
    flight_t     infl[$];
    mreq_t       mq[$];
    logic [31:0] m_fetch_pc;
    logic        m_rv;
    int          cyc;
    int          last_due;
    int          lat;

    // stimulus knobs: percentages, reset in per-mille
    int          p_ready;
    int          p_req;
    int          p_redir;
    int          p_rst;
    bit          tgt_rand;
    logic [31:0] fx_target;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic model_reset();
        fq.delete();
        infl.delete();
        mq.delete();
        m_fetch_pc = 32'h0;
        last_due   = 0;
    endtask

    // Drive this cycle's inputs, then compare the DUT outputs against the model at the negedge.
    task automatic cyc_begin();
        rst              = ($urandom_range(999) >= p_rst);
        instr_ready_i    = ($urandom_range(99) < p_ready);
        imem_req_ready_i = ($urandom_range(99) < p_req);
        redirect_i       = rst && ($urandom_range(99) < p_redir);
        redirect_pc_i    = tgt_rand ? $urandom : fx_target;
        if (rst && (mq.size() > 0) && (mq[0].due <= cyc)) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_data(mq[0].addr);
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
        end
        @(negedge clk);
        m_rv = rst && ((fq.size() + infl.size()) < DEPTH);
        chk("req_valid", {31'b0, imem_req_valid_o}, {31'b0, m_rv});
        if (m_rv) chk("req_addr", imem_req_addr_o, m_fetch_pc);
        if (fq.size() > 0) begin
            chk("instr_valid", {31'b0, instr_valid_o}, 32'd1);
            chk("instr", instr_o, fq[0].instr);
            chk("pc", pc_o, fq[0].pc);
            chk("pc_plus4", pc_plus4_o, fq[0].pc + 32'd4);
        end else begin
            chk("instr_valid", {31'b0, instr_valid_o}, 32'd0);
            chk("instr_empty", instr_o, NOP);
            chk("pc_empty", pc_o, 32'h0);
            chk("pc_plus4_empty", pc_plus4_o, 32'h0);
        end
    endtask

    // Apply this cycle's events to the model, then move to just after the next rising edge.
    task automatic cyc_end();
        bit      pop;
        bit      hs;
        flight_t f;
        mreq_t   m;
        entry_t  e;
        int      due;
        if (!rst) begin
            model_reset();
        end else begin
            hs  = m_rv && imem_req_ready_i;
            pop = (fq.size() > 0) && instr_ready_i && !redirect_i;
            if (pop) fq.delete(0);
            if (imem_rsp_valid_i) begin
                f = infl.pop_front();
                m = mq.pop_front();
                if (!f.stale && !redirect_i) begin
                    e.instr = imem_rsp_data_i;
                    e.pc    = f.pc;
                    fq.push_back(e);
                end
            end
            if (hs) begin
                f.pc    = m_fetch_pc;
                f.stale = redirect_i;
                infl.push_back(f);
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                m.addr = m_fetch_pc;
                m.due  = due;
                mq.push_back(m);
                last_due   = due;
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            if (redirect_i) begin
                fq.delete();
                for (int i = 0; i < infl.size(); i++) infl[i].stale = 1'b1;
                m_fetch_pc = {redirect_pc_i[31:2], 2'b00};
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        p_rst = 1000;
        cyc_begin();
        cyc_end();
        p_rst = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_req_ready_i = 1'b0; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
        instr_ready_i = 1'b0;
        cyc = 0; lat = 1; m_rv = 1'b0;
        p_ready = 100; p_req = 100; p_redir = 0; p_rst = 0;
        tgt_rand = 1'b0; fx_target = 32'h0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_pc4", pc_plus4_o, 32'h0);
        chk("rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
        @(posedge clk);
        #1;

        // reset release, L = 1, decode always ready
        for (int i = 0; i < 10; i++) begin
            cyc_begin();
            if (i == 0) chk("t1_addr0", imem_req_addr_o, 32'h0);
            if (i == 1) begin
                chk("t1_addr1", imem_req_addr_o, 32'h4);
                chk("t1_nvalid1", {31'b0, instr_valid_o}, 32'd0);
            end
            if (i == 2) begin
                chk("t1_valid2", {31'b0, instr_valid_o}, 32'd1);
                chk("t1_pc2", pc_o, 32'h0);
                chk("t1_pc4_2", pc_plus4_o, 32'h4);
            end
            if (i == 5) chk("t1_pc5", pc_o, 32'hC);
            cyc_end();
        end

        // decode stalled: queue fills, requests stop, then drain in order
        do_reset();
        p_ready = 0;
        for (int i = 0; i < 8; i++) begin
            cyc_begin();
            if (i == 7) begin
                chk("t2_req_stop", {31'b0, imem_req_valid_o}, 32'd0);
                chk("t2_head_pc", pc_o, 32'h0);
            end
            cyc_end();
        end
        p_ready = 100;
        for (int i = 0; i < 4; i++) begin
            cyc_begin();
            chk("t2_drain_pc", pc_o, 32'(i * 4));
            if (i == 1) begin
                chk("t2_req_resume", {31'b0, imem_req_valid_o}, 32'd1);
                chk("t2_req_addr", imem_req_addr_o, 32'h10);
            end
            cyc_end();
        end

        // L = 3, three in flight, redirect to an unaligned target
        do_reset();
        lat = 3;
        for (int i = 0; i < 5; i++) begin
            p_req     = (i == 3) ? 0 : 100;
            p_redir   = (i == 3) ? 100 : 0;
            fx_target = 32'h0000_0103;
            cyc_begin();
            if (i == 4) begin
                chk("t3_req_valid", {31'b0, imem_req_valid_o}, 32'd1);
                chk("t3_req_addr", imem_req_addr_o, 32'h100);
                chk("t3_nvalid", {31'b0, instr_valid_o}, 32'd0);
            end
            cyc_end();
        end
        p_redir = 0;
        p_req   = 100;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc_begin();
            if (instr_valid_o) begin
                chk("t3_first_pc", pc_o, 32'h100);
                seen = 1'b1;
            end
            cyc_end();
        end
        chk("t3_timeout", {31'b0, seen}, 32'd1);

        // redirect in the same cycle as a response and a request handshake
        do_reset();
        lat = 1;
        fx_target = 32'h0000_0200;
        for (int i = 0; i < 8; i++) begin
            p_redir = (i == 3) ? 100 : 0;
            cyc_begin();
            if (i == 3) chk("t4_req_hs", {31'b0, imem_req_valid_o}, 32'd1);
            if (i == 4) begin
                chk("t4_nvalid4", {31'b0, instr_valid_o}, 32'd0);
                chk("t4_addr4", imem_req_addr_o, 32'h200);
            end
            if (i == 5) chk("t4_nvalid5", {31'b0, instr_valid_o}, 32'd0);
            if (i == 6) chk("t4_pc6", pc_o, 32'h200);
            cyc_end();
        end

        // fetch address wrap at 2^32
        fx_target = 32'hFFFF_FFFC;
        for (int i = 0; i < 6; i++) begin
            p_redir = (i == 0) ? 100 : 0;
            cyc_begin();
            if (i == 1) chk("t5_addr_top", imem_req_addr_o, 32'hFFFF_FFFC);
            if (i == 2) chk("t5_addr_wrap", imem_req_addr_o, 32'h0);
            if (i == 3) begin
                chk("t5_pc_top", pc_o, 32'hFFFF_FFFC);
                chk("t5_pc4_wrap", pc_plus4_o, 32'h0);
            end
            if (i == 4) chk("t5_pc_wrap", pc_o, 32'h0);
            cyc_end();
        end

        // reset mid-stream with the queue full
        p_ready = 0;
        for (int i = 0; i < 8; i++) begin
            cyc_begin();
            cyc_end();
        end
        p_rst = 1000;
        cyc_begin();
        chk("t6_req_in_rst", {31'b0, imem_req_valid_o}, 32'd0);
        cyc_end();
        p_rst   = 0;
        p_ready = 100;
        cyc_begin();
        chk("t6_nvalid", {31'b0, instr_valid_o}, 32'd0);
        chk("t6_nop", instr_o, NOP);
        chk("t6_req_valid", {31'b0, imem_req_valid_o}, 32'd1);
        chk("t6_req_addr", imem_req_addr_o, 32'h0);
        cyc_end();

        // randomized segments
        tgt_rand = 1'b1;
        for (int s = 0; s < 10; s++) begin
            lat     = $urandom_range(4, 1);
            p_ready = $urandom_range(100, 20);
            p_req   = $urandom_range(100, 30);
            p_redir = $urandom_range(8, 0);
            p_rst   = 3;
            for (int i = 0; i < 250; i++) begin
                cyc_begin();
                cyc_end();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_buffer.md
# instr_prefetch_buffer

Instruction prefetch buffer between instruction memory and the fetch/decode pipeline register. Issues sequential word fetches to a variable-latency instruction memory, holds up to DEPTH returned instructions with their PCs in a FIFO, and presents them one per cycle to the decode stage. On a taken branch/jump from execute, it flushes queued and in-flight fetches and restarts at the target.

## Interface
- DEPTH, 4: queue entries and maximum outstanding requests; power of two, ≥2
- RESET_PC, 32'h0000_0000: first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- redirect_i  in  1  taken control transfer from execute (PCSrcE)
- redirect_pc_i  in  32  target address (PCTargetE); bits [1:0] ignored, treated as 0
- imem_req_valid_o  out  1  fetch request valid
- imem_req_ready_i  in  1  memory accepts request
- imem_req_addr_o  out  32  word-aligned fetch address
- imem_rsp_valid_i  in  1  returned instruction valid; in-order; no back-pressure
- imem_rsp_data_i  in  32  returned instruction
- instr_valid_o  out  1  queue head valid
- instr_ready_i  in  1  decode consumes head (low = stall)
- instr_o  out  32  head instruction; 32'h0000_0013 (NOP) when empty
- pc_o  out  32  head PC; 0 when empty
- pc_plus4_o  out  32  pc_o + 4 (mod 2^32); 0 when empty

## Operation
- State: fetch_pc, FIFO of {instr, pc} (DEPTH entries, rd/wr pointers, count), outstanding counter (0..DEPTH), drop counter (0..DEPTH).
- Credit rule: imem_req_valid_o = rst && (count + outstanding < DEPTH). Guarantees every non-dropped response has a free slot.
- Request handshake (valid && ready): PC tag pushed to an internal tag FIFO, fetch_pc += 4 (wraps at 2^32), outstanding += 1.
- Response: if drop > 0, discard and drop -= 1; else write {imem_rsp_data_i, tag} to FIFO. outstanding -= 1 in both cases.
- Dequeue: instr_valid_o && instr_ready_i pops head.
- Redirect (redirect_i = 1), takes priority over every other event in that cycle:
  - FIFO count ← 0; dequeue ignored.
  - fetch_pc ← {redirect_pc_i[31:2], 2'b00}.
  - drop ← outstanding + (req handshake this cycle) − (rsp valid this cycle); a response arriving in the redirect cycle is discarded.
  - outstanding updated normally; tag FIFO cleared consistently.
- Simultaneous push and pop with full FIFO is legal; count unchanged.
- Response with no outstanding request is a protocol violation; assertion fires, behaviour undefined.
- Reset (rst = 0 at an edge, including mid-operation): fetch_pc ← RESET_PC, count/outstanding/drop ← 0, all outputs to empty values, imem_req_valid_o = 0. Responses to pre-reset requests must not arrive after reset (memory reset together).

## Timing
- Request accepted cycle T, response cycle T+L (L ≥ 1), entry visible on instr_valid_o at T+L+1 (no bypass build).
- Redirect in cycle R: instr_valid_o = 0 in R+1; first target request offered in R+1; with L = 1, target instruction on outputs at R+3.
- Steady state with L = 1, ready held high: one instruction per cycle after fill, provided DEPTH ≥ 2.
- All outputs come from registers, except imem_req_valid_o (counter compare) and bypass path below.

## Configuration
- IPB_BYPASS_EN defined: when FIFO empty, drop = 0, redirect_i = 0, and imem_rsp_valid_i = 1, response drives instr_valid_o/instr_o/pc_o/pc_plus4_o combinationally in the same cycle; if instr_ready_i = 1 it is not written into the FIFO. Fetch-to-decode latency becomes L.
- Not defined: no combinational path from imem response to outputs; latency L+1 as above.

## Test plan
- Reset release with L = 1, ready high: requests 0x0, 0x4, 0x8…; instr_valid_o first high at cycle 2 with pc_o = 0x0, pc_plus4_o = 0x4; then one per cycle.
- Hold instr_ready_i low: after 4 responses, imem_req_valid_o = 0 and count = 4; release ready -> heads 0x0..0xC drain in order, requests resume.
- L = 3 with 3 outstanding, redirect_i with redirect_pc_i = 0x103: 3 stale responses discarded, next request address 0x100, first output pc_o = 0x100.
- Redirect in same cycle as response and request handshake: that response dropped, drop = outstanding + 1 − 1, no stale PC ever on pc_o.
- fetch_pc = 0xFFFF_FFFC: next request address 0x0, pc_plus4_o = 0x0 for that entry.
- rst low mid-stream with FIFO full: next cycle instr_valid_o = 0, instr_o = 0x0000_0013, first request 0x0 after release.
